nib_data_responder: RTL and testbench
=====================================

NIB_DATA_RESPONDER -- requirements
Module: nib_data_responder

Interface
REQ-001 SHALL have parameter AW, default 12, meaning word-address width (2**AW words of storage).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning byte base of the mapped window.
REQ-003 SHALL have parameter OOR_DATA, default 32'h0000_0000, meaning read data returned for an out-of-range address.
REQ-004 Ports: clk  in  1  single clock, all state on rising edge.
REQ-005 Ports: rst  in  1  asynchronous, active-high reset.
REQ-006 Ports: nib_ex_req_i  in  1  core data request; nib_ex_we_i  in  1  1=write, 0=read.
REQ-007 Ports: nib_ex_addr_i  in  32  byte address; nib_ex_data_i  in  32  core write data.
REQ-008 Ports: nib_ex_data_o  out  32  core read data; nib_hold_req_o  out  1  core stall request.
REQ-009 Ports: dma_req_i, dma_we_i  in  1 each; dma_addr_i, dma_wdata_i  in  32 each.
REQ-010 Ports: dma_gnt_o  out  1; dma_rvalid_o  out  1; dma_rdata_o  out  32.
REQ-011 Ports: oor_err_o  out  1  sticky range error; err_clr_i  in  1; hold_cnt_o  out  32  stall-cycle counter.

Function
REQ-012 Storage: 2**AW x 32 synchronous-read single-port array; one access per cycle.
REQ-013 Decode: word index = (addr-BASE_ADDR)[AW+1:2]; addr[1:0] ignored; addr outside [BASE_ADDR, BASE_ADDR+4*2**AW) is out-of-range.
REQ-014 FSM states IDLE, CORE_RD, DMA_RD; reset state IDLE.
REQ-015 IDLE arbitration: DMA wins if dma_req_i and (!nib_ex_req_i or !last_dma); otherwise core wins if nib_ex_req_i; last_dma set on DMA grant, cleared on core grant.
REQ-016 dma_gnt_o SHALL be combinational, high only in IDLE on the cycle DMA wins.
REQ-017 Write (either master) commits at the granting edge, one cycle, state stays IDLE; core write SHALL NOT raise hold.
REQ-018 Core read in IDLE: nib_hold_req_o=1 that cycle, state->CORE_RD; in CORE_RD nib_hold_req_o=0 and nib_ex_data_o=array data; next state IDLE.
REQ-019 nib_hold_req_o SHALL be 1 in IDLE or DMA_RD whenever nib_ex_req_i is high and core not granted a write in that cycle; core holds req/addr/we stable while held.
REQ-020 DMA read in IDLE -> DMA_RD; in DMA_RD dma_rvalid_o=1 for exactly one cycle with dma_rdata_o valid; next state IDLE.
REQ-021 No grant in CORE_RD or DMA_RD; requests arriving then wait for IDLE.
REQ-022 nib_ex_data_o and dma_rdata_o SHALL be registered-hold: keep last returned value outside their valid cycle.
REQ-023 Out-of-range: read returns OOR_DATA with normal latency, write discarded; oor_err_o sets next edge.
REQ-024 err_clr_i clears oor_err_o; simultaneous set and clear -> set wins.
REQ-025 Read-after-write same address on the next cycle SHALL return the new data.
REQ-026 hold_cnt_o increments each cycle nib_hold_req_o=1, saturates at 32'hFFFF_FFFF.

Reset
REQ-027 On rst: state IDLE, last_dma=0, nib_ex_data_o=0, dma_rdata_o=0, dma_rvalid_o=0, dma_gnt_o=0, nib_hold_req_o=0, oor_err_o=0, hold_cnt_o=0; array contents not reset.
REQ-028 Reset mid-read (CORE_RD/DMA_RD) SHALL abort the access with no valid pulse; any new request after release restarts from IDLE.

Structure
REQ-029 FSM state enum and default BASE_ADDR/OOR_DATA constants SHALL live in rvv_pkg.
REQ-030 Storage SHALL be one sub-module nib_sram_sp (sync read, write-first not required, 1 port).

Verification
REQ-031 Core write 0x0000_0010<-0xA5A5_0001, then read 0x10 -> hold=1 one cycle, next cycle data_o=0xA5A5_0001, hold=0.
REQ-032 Core read and DMA read same cycle, last_dma=0 -> dma_gnt_o=1, core hold 2 cycles, core served next IDLE, hold_cnt_o=3.
REQ-033 Continuous DMA+core requests for 20 cycles -> grants alternate, core never starved beyond one DMA access.
REQ-034 Core read 0x0000_4000 (AW=12) -> data_o=OOR_DATA, oor_err_o=1; err_clr_i pulse -> 0.
REQ-035 DMA write 0x20<-0x1234_5678, next-cycle core read 0x20 -> 0x1234_5678.
REQ-036 rst asserted during CORE_RD -> outputs to reset values immediately, no data_o update, FSM IDLE.

Source files
------------

// File: rtl/rvv_pkg.sv
// Shared types and default constants for the NIB data responder.
// Holds the responder FSM encoding and the default window parameters.
package rvv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CORE_RD = 2'd1,
        ST_DMA_RD  = 2'd2
    } nib_state_e;

    localparam logic [31:0] NIB_BASE_ADDR_DEF = 32'h0000_0000;
    localparam logic [31:0] NIB_OOR_DATA_DEF  = 32'h0000_0000;

    // True when a byte offset from the window base lands inside 2**aw words.
    function automatic logic nib_in_window(input logic [31:0] off, input int unsigned aw);
        return (off >> (aw + 2)) == 32'd0;
    endfunction

endpackage

// File: rtl/nib_sram_sp.sv
// Single-port synchronous-read word store for the NIB data responder.
// One access per cycle; read data appears the cycle after the enable.
module nib_sram_sp #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    // Array write or registered read, never both in one cycle.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/nib_data_responder.sv
// Data-side responder arbitrating a core port and a DMA port onto one SRAM.
// Reads take one extra cycle; core reads stall the core through hold.
module nib_data_responder
    import rvv_pkg::*;
#(
    parameter int unsigned AW        = 12,
    parameter logic [31:0] BASE_ADDR = NIB_BASE_ADDR_DEF,
    parameter logic [31:0] OOR_DATA  = NIB_OOR_DATA_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nib_ex_req_i,
    input  logic        nib_ex_we_i,
    input  logic [31:0] nib_ex_addr_i,
    input  logic [31:0] nib_ex_data_i,
    output logic [31:0] nib_ex_data_o,
    output logic        nib_hold_req_o,
    input  logic        dma_req_i,
    input  logic        dma_we_i,
    input  logic [31:0] dma_addr_i,
    input  logic [31:0] dma_wdata_i,
    output logic        dma_gnt_o,
    output logic        dma_rvalid_o,
    output logic [31:0] dma_rdata_o,
    output logic        oor_err_o,
    input  logic        err_clr_i,
    output logic [31:0] hold_cnt_o
);

    nib_state_e  state_q, state_d;
    logic        last_dma_q, last_dma_d;
    logic        rd_oor_q, rd_oor_d;
    logic        oor_err_q, oor_err_d;
    logic [31:0] core_data_q, core_data_d;
    logic [31:0] dma_data_q, dma_data_d;
    logic [31:0] hold_cnt_q, hold_cnt_d;

    logic [31:0] core_off, dma_off;
    logic        core_in, dma_in;
    logic        dma_win, dma_gnt, hold, acc_oor;
    logic        mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata, rd_val;

    assign core_off = nib_ex_addr_i - BASE_ADDR;
    assign dma_off  = dma_addr_i - BASE_ADDR;
    assign core_in  = nib_in_window(core_off, AW);
    assign dma_in   = nib_in_window(dma_off, AW);
    assign dma_win  = dma_req_i && (!nib_ex_req_i || !last_dma_q);

    // Arbitration, SRAM port steering and FSM next state.
    always_comb begin
        state_d    = state_q;
        last_dma_d = last_dma_q;
        dma_gnt    = 1'b0;
        hold       = 1'b0;
        acc_oor    = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (rst) begin
                    hold = 1'b0;
                end else if (dma_req_i && dma_win) begin
                    dma_gnt    = 1'b1;
                    last_dma_d = 1'b1;
                    hold       = nib_ex_req_i;
                    acc_oor    = !dma_in;
                    mem_en     = 1'b1;
                    mem_we     = dma_we_i && dma_in;
                    mem_addr   = dma_off[AW+1:2];
                    mem_wdata  = dma_wdata_i;
                    if (!dma_we_i) state_d = ST_DMA_RD;
                end else if (nib_ex_req_i) begin
                    last_dma_d = 1'b0;
                    hold       = !nib_ex_we_i;
                    acc_oor    = !core_in;
                    mem_en     = 1'b1;
                    mem_we     = nib_ex_we_i && core_in;
                    mem_addr   = core_off[AW+1:2];
                    mem_wdata  = nib_ex_data_i;
                    if (!nib_ex_we_i) state_d = ST_CORE_RD;
                end
            end
            ST_CORE_RD: begin
                state_d = ST_IDLE;
            end
            ST_DMA_RD: begin
                hold    = nib_ex_req_i && !rst;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rd_val = rd_oor_q ? OOR_DATA : mem_rdata;

    // Next values for held read data, error flag and stall counter.
    always_comb begin
        rd_oor_d    = acc_oor;
        core_data_d = core_data_q;
        dma_data_d  = dma_data_q;
        oor_err_d   = oor_err_q;
        hold_cnt_d  = hold_cnt_q;
        if (state_q == ST_CORE_RD) core_data_d = rd_val;
        if (state_q == ST_DMA_RD)  dma_data_d  = rd_val;
        if (acc_oor) begin
            oor_err_d = 1'b1;
        end else if (err_clr_i) begin
            oor_err_d = 1'b0;
        end
        if (hold && hold_cnt_q != 32'hFFFF_FFFF) begin
            hold_cnt_d = hold_cnt_q + 32'd1;
        end
    end

    // State and datapath registers; a reset aborts any read in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_dma_q  <= 1'b0;
            rd_oor_q    <= 1'b0;
            oor_err_q   <= 1'b0;
            core_data_q <= '0;
            dma_data_q  <= '0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_dma_q  <= last_dma_d;
            rd_oor_q    <= rd_oor_d;
            oor_err_q   <= oor_err_d;
            core_data_q <= core_data_d;
            dma_data_q  <= dma_data_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    nib_sram_sp #(
        .AW (AW),
        .DW (32)
    ) u_sram (
        .clk     (clk),
        .en_i    (mem_en),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    assign nib_ex_data_o  = (state_q == ST_CORE_RD) ? rd_val : core_data_q;
    assign dma_rdata_o    = (state_q == ST_DMA_RD) ? rd_val : dma_data_q;
    assign dma_rvalid_o   = (state_q == ST_DMA_RD);
    assign dma_gnt_o      = dma_gnt;
    assign nib_hold_req_o = hold;
    assign oor_err_o      = oor_err_q;
    assign hold_cnt_o     = hold_cnt_q;

endmodule

// File: tb/tb_nib_data_responder.sv
// Scoreboard bench for nib_data_responder with directed core/DMA traffic.
// Drivers queue expected read data; a negedge monitor pops and compares.
module tb_nib_data_responder;

    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam logic [31:0] OORD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nib_ex_req_i = 1'b0;
    logic        nib_ex_we_i = 1'b0;
    logic [31:0] nib_ex_addr_i = '0;
    logic [31:0] nib_ex_data_i = '0;
    logic [31:0] nib_ex_data_o;
    logic        nib_hold_req_o;
    logic        dma_req_i = 1'b0;
    logic        dma_we_i = 1'b0;
    logic [31:0] dma_addr_i = '0;
    logic [31:0] dma_wdata_i = '0;
    logic        dma_gnt_o;
    logic        dma_rvalid_o;
    logic [31:0] dma_rdata_o;
    logic        oor_err_o;
    logic        err_clr_i = 1'b0;
    logic [31:0] hold_cnt_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] core_q[$];
    logic [31:0] dma_q[$];
    int dma_run = 0;
    int run_viol = 0;
    int contention = 0;

    always #5 clk = ~clk;

    nib_data_responder #(
        .AW        (12),
        .BASE_ADDR (BASE),
        .OOR_DATA  (OORD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .nib_ex_req_i   (nib_ex_req_i),
        .nib_ex_we_i    (nib_ex_we_i),
        .nib_ex_addr_i  (nib_ex_addr_i),
        .nib_ex_data_i  (nib_ex_data_i),
        .nib_ex_data_o  (nib_ex_data_o),
        .nib_hold_req_o (nib_hold_req_o),
        .dma_req_i      (dma_req_i),
        .dma_we_i       (dma_we_i),
        .dma_addr_i     (dma_addr_i),
        .dma_wdata_i    (dma_wdata_i),
        .dma_gnt_o      (dma_gnt_o),
        .dma_rvalid_o   (dma_rvalid_o),
        .dma_rdata_o    (dma_rdata_o),
        .oor_err_o      (oor_err_o),
        .err_clr_i      (err_clr_i),
        .hold_cnt_o     (hold_cnt_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout got none expected response", name);
    endtask

    // Monitor: core read completes when held request sees hold drop.
    always @(negedge clk) begin
        if (!rst) begin
            if (nib_ex_req_i && !nib_hold_req_o) begin
                dma_run = 0;
                if (!nib_ex_we_i) begin
                    if (core_q.size() == 0) check("core_unexpected", nib_ex_data_o, 32'hx);
                    else check("core_rdata", nib_ex_data_o, core_q.pop_front());
                end
            end
            if (dma_rvalid_o) begin
                if (dma_q.size() == 0) check("dma_unexpected", dma_rdata_o, 32'hx);
                else check("dma_rdata", dma_rdata_o, dma_q.pop_front());
            end
            if (dma_gnt_o && nib_ex_req_i && nib_hold_req_o) begin
                contention++;
                dma_run++;
                if (dma_run > 1) run_viol++;
            end
        end
    end

    task automatic core_acc(input logic we, input logic [31:0] a, input logic [31:0] d);
        int n;
        nib_ex_req_i  = 1'b1;
        nib_ex_we_i   = we;
        nib_ex_addr_i = a;
        nib_ex_data_i = d;
        n = 0;
        forever begin
            @(negedge clk);
            if (!nib_hold_req_o) break;
            n++;
            if (n > 40) begin
                timeout("core_wait");
                break;
            end
        end
        @(posedge clk);
        #1;
        nib_ex_req_i = 1'b0;
    endtask

    task automatic core_wr(input logic [31:0] a, input logic [31:0] d);
        core_acc(1'b1, a, d);
    endtask

    task automatic core_rd(input logic [31:0] a, input logic [31:0] exp);
        core_q.push_back(exp);
        core_acc(1'b0, a, 32'h0);
    endtask

    task automatic dma_acc(input logic we, input logic [31:0] a, input logic [31:0] d);
        int n;
        dma_req_i   = 1'b1;
        dma_we_i    = we;
        dma_addr_i  = a;
        dma_wdata_i = d;
        n = 0;
        forever begin
            @(negedge clk);
            if (dma_gnt_o) break;
            n++;
            if (n > 40) begin
                timeout("dma_wait");
                break;
            end
        end
        @(posedge clk);
        #1;
        dma_req_i = 1'b0;
    endtask

    task automatic dma_rd(input logic [31:0] a, input logic [31:0] exp);
        dma_q.push_back(exp);
        dma_acc(1'b0, a, 32'h0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_data_o", nib_ex_data_o, 32'h0);
        check("rst_dma_rdata", dma_rdata_o, 32'h0);
        check("rst_rvalid", {31'h0, dma_rvalid_o}, 32'h0);
        check("rst_gnt", {31'h0, dma_gnt_o}, 32'h0);
        check("rst_oor", {31'h0, oor_err_o}, 32'h0);
        check("rst_cnt", hold_cnt_o, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        core_wr(BASE + 32'h10, 32'hA5A5_0001);
        core_rd(BASE + 32'h10, 32'hA5A5_0001);
        check("cnt_after_rd", hold_cnt_o, 32'd1);

        dma_acc(1'b1, BASE + 32'h20, 32'h1234_5678);
        core_rd(BASE + 32'h20, 32'h1234_5678);
        check("cnt_raw", hold_cnt_o, 32'd2);

        fork
            core_rd(BASE + 32'h10, 32'hA5A5_0001);
            dma_rd(BASE + 32'h20, 32'h1234_5678);
        join
        check("cnt_contend", hold_cnt_o, 32'd5);
        check("contend_seen", contention, 1);

        core_q.push_back(OORD);
        nib_ex_req_i  = 1'b1;
        nib_ex_we_i   = 1'b0;
        nib_ex_addr_i = BASE + 32'h4000;
        err_clr_i     = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        err_clr_i = 1'b0;
        @(negedge clk);
        check("oor_set_wins", {31'h0, oor_err_o}, 32'h1);
        @(posedge clk);
        #1;
        nib_ex_req_i = 1'b0;
        err_clr_i = 1'b1;
        @(posedge clk);
        #1;
        err_clr_i = 1'b0;
        @(negedge clk);
        check("oor_cleared", {31'h0, oor_err_o}, 32'h0);

        core_wr(32'h0000_0010, 32'hBAD0_0001);
        check("oor_low_wr", {31'h0, oor_err_o}, 32'h1);
        core_wr(BASE + 32'h4010, 32'hBAD0_0002);
        core_rd(BASE + 32'h10, 32'hA5A5_0001);
        dma_rd(BASE - 32'h4, OORD);
        err_clr_i = 1'b1;
        @(posedge clk);
        #1;
        err_clr_i = 1'b0;

        fork
            repeat (5) core_rd(BASE + 32'h10, 32'hA5A5_0001);
            repeat (5) dma_rd(BASE + 32'h20, 32'h1234_5678);
        join
        check("no_starve", run_viol, 0);
        check("alt_contend", {31'h0, contention > 3}, 32'h1);

        repeat (3) @(negedge clk);
        check("hold_core_data", nib_ex_data_o, 32'hA5A5_0001);
        check("hold_dma_data", dma_rdata_o, 32'h1234_5678);
        check("rvalid_idle", {31'h0, dma_rvalid_o}, 32'h0);

        @(posedge clk);
        #1;
        core_q.push_back(32'hA5A5_0001);
        nib_ex_req_i  = 1'b1;
        nib_ex_we_i   = 1'b0;
        nib_ex_addr_i = BASE + 32'h10;
        @(negedge clk);
        check("midrd_hold", {31'h0, nib_hold_req_o}, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        nib_ex_req_i = 1'b0;
        @(negedge clk);
        check("midrd_data_o", nib_ex_data_o, 32'h0);
        check("midrd_dma_rdata", dma_rdata_o, 32'h0);
        check("midrd_hold_o", {31'h0, nib_hold_req_o}, 32'h0);
        check("midrd_cnt", hold_cnt_o, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        core_acc(1'b0, BASE + 32'h10, 32'h0);
        check("after_rst_cnt", hold_cnt_o, 32'd1);

        repeat (3) @(negedge clk);
        check("core_q_empty", core_q.size(), 32'd0);
        check("dma_q_empty", dma_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running expected done");
        $fatal(1);
    end

endmodule
